// File: rtl/latch_seq_pkg.sv
// Shared definitions for the latch write sequencer.
//   seq_state_e    : sequencer phase (idle, data setup, gate pulse, data hold, bank clear)
//   addr_width()   : address width for a given number of latch words (never below 1)
//   cnt_width()    : phase counter width able to hold the largest (cycles - 1) load value
//   gate_hit()     : one-hot gate decode, evaluated per gate line
package latch_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StClear
  } seq_state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The counter is loaded with (cycles - 1), so it only needs to hold max - 1.
  function automatic int unsigned cnt_width(input int unsigned setup_cyc,
                                            input int unsigned pulse_cyc,
                                            input int unsigned hold_cyc);
    int unsigned m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic gate_hit(input int unsigned addr, input int unsigned line);
    return addr == line;
  endfunction

endpackage

// File: rtl/latch_seq_timer.sv
// Loadable down-counter shared by all sequencer phases.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (count returns to 0)
//   load_i     : load load_val_i this cycle
//   load_val_i : phase length minus one
//   tc_o       : terminal count, high while the count is 0 (last cycle of a phase)
module latch_seq_timer #(
  parameter int unsigned CntW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Write-side sequencer for a bank of transparent-high, active-low-clear latches.
// Each accepted word is driven on LAT_D, then its gate line pulses with programmable
// setup / pulse / hold spacing; a clear request pulses LAT_RSTB low instead.
// Ports:
//   CLK, RST            : clock (rising edge) and synchronous active-high reset
//   IN_VALID, IN_READY  : write request handshake (CLR_REQ shares IN_READY and wins ties)
//   IN_ADDR, IN_DATA    : target latch word and write data
//   CLR_REQ             : clear-all request
//   LAT_D, LAT_G        : latch data bus and one-hot gate enables
//   LAT_RSTB            : active-low clear to the latch bank
//   BUSY, DONE, ERR     : not idle / completion pulse / dropped out-of-range request pulse
// Optional: define LATCH_WRITE_SEQ_VERIFY_EN to add LAT_Q (read-back of the addressed word)
// and MISMATCH (pulses with DONE when the read-back disagrees with the written/cleared value).
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1,
  localparam int unsigned ADDR_W   = addr_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [WIDTH-1:0]  IN_DATA,
  input  logic              CLR_REQ,
`ifdef LATCH_WRITE_SEQ_VERIFY_EN
  input  logic [WIDTH-1:0]  LAT_Q,
  output logic              MISMATCH,
`endif
  output logic [WIDTH-1:0]  LAT_D,
  output logic [DEPTH-1:0]  LAT_G,
  output logic              LAT_RSTB,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned CntW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  lat_d_q, lat_d_d;
  logic [DEPTH-1:0]  lat_g_q, lat_g_d;
  logic              in_ready_q, in_ready_d;
  logic              lat_rstb_q, lat_rstb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tmr_load;
  logic [CntW-1:0]   tmr_load_val;
  logic              tmr_tc;
  logic              clr_acc, wr_acc, addr_ok;

  latch_seq_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tc_o       (tmr_tc)
  );

  // Clear wins a tie; the write stays pending on IN_VALID and is taken next time.
  assign clr_acc = in_ready_q & CLR_REQ;
  assign wr_acc  = in_ready_q & ~CLR_REQ & IN_VALID;
  assign addr_ok = 32'(IN_ADDR) < DEPTH;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d_d      = lat_d_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr_acc) begin
          state_d      = StClear;
          tmr_load     = 1'b1;
          tmr_load_val = CntW'(PULSE_CYC - 1);
        end else if (wr_acc) begin
          if (addr_ok) begin
            state_d      = StSetup;
            addr_d       = IN_ADDR;
            lat_d_d      = IN_DATA;
            tmr_load     = 1'b1;
            tmr_load_val = CntW'(SETUP_CYC - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (tmr_tc) begin
          state_d      = StPulse;
          tmr_load     = 1'b1;
          tmr_load_val = CntW'(PULSE_CYC - 1);
        end
      end
      StPulse: begin
        if (tmr_tc) begin
          state_d      = StHold;
          tmr_load     = 1'b1;
          tmr_load_val = CntW'(HOLD_CYC - 1);
        end
      end
      StHold: begin
        if (tmr_tc) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StClear: begin
        if (tmr_tc) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they are registered yet phase-aligned.
    in_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    lat_rstb_d = (state_d != StClear);
    lat_g_d    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lat_g_d[i] = (state_d == StPulse) && gate_hit(32'(addr_d), i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      lat_d_q    <= '0;
      lat_g_q    <= '0;
      in_ready_q <= 1'b0;
      lat_rstb_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lat_d_q    <= lat_d_d;
      lat_g_q    <= lat_g_d;
      in_ready_q <= in_ready_d;
      lat_rstb_q <= lat_rstb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign IN_READY = in_ready_q;
  assign LAT_D    = lat_d_q;
  assign LAT_G    = lat_g_q;
  assign LAT_RSTB = lat_rstb_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

`ifdef LATCH_WRITE_SEQ_VERIFY_EN
  logic mismatch_q, mismatch_d;

  // Read-back is judged in the final cycle of the phase so it lines up with DONE.
  always_comb begin
    mismatch_d = 1'b0;
    if (tmr_tc && (state_q == StHold)) begin
      mismatch_d = (LAT_Q != lat_d_q);
    end else if (tmr_tc && (state_q == StClear)) begin
      mismatch_d = (LAT_Q != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign MISMATCH = mismatch_q;
`endif

endmodule

// File: tb/tb_latch_write_sequencer.sv
module tb_latch_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       clr_req;
  logic [1:0] in_addr;
  logic [7:0] in_data;

  logic       def_ready, def_rstb, def_busy, def_done, def_err;
  logic [7:0] def_d;
  logic [3:0] def_g;
  logic       lng_ready, lng_rstb, lng_busy, lng_done, lng_err;
  logic [7:0] lng_d;
  logic [3:0] lng_g;
  logic       d3_ready, d3_rstb, d3_busy, d3_done, d3_err;
  logic [7:0] d3_d;
  logic [2:0] d3_g;
`ifdef LATCH_WRITE_SEQ_VERIFY_EN
  logic [7:0] lat_q;
  logic       def_mm, lng_mm, d3_mm;
`endif

  int n_pass;
  int n_checks;

  always #5 clk = ~clk;

  latch_write_sequencer u_def (
    .CLK (clk), .RST (rst), .IN_VALID (in_valid), .IN_READY (def_ready),
    .IN_ADDR (in_addr), .IN_DATA (in_data), .CLR_REQ (clr_req),
`ifdef LATCH_WRITE_SEQ_VERIFY_EN
    .LAT_Q (lat_q), .MISMATCH (def_mm),
`endif
    .LAT_D (def_d), .LAT_G (def_g), .LAT_RSTB (def_rstb),
    .BUSY (def_busy), .DONE (def_done), .ERR (def_err)
  );

  latch_write_sequencer #(
    .SETUP_CYC (2), .PULSE_CYC (3), .HOLD_CYC (2)
  ) u_lng (
    .CLK (clk), .RST (rst), .IN_VALID (in_valid), .IN_READY (lng_ready),
    .IN_ADDR (in_addr), .IN_DATA (in_data), .CLR_REQ (clr_req),
`ifdef LATCH_WRITE_SEQ_VERIFY_EN
    .LAT_Q (lat_q), .MISMATCH (lng_mm),
`endif
    .LAT_D (lng_d), .LAT_G (lng_g), .LAT_RSTB (lng_rstb),
    .BUSY (lng_busy), .DONE (lng_done), .ERR (lng_err)
  );

  latch_write_sequencer #(
    .DEPTH (3)
  ) u_d3 (
    .CLK (clk), .RST (rst), .IN_VALID (in_valid), .IN_READY (d3_ready),
    .IN_ADDR (in_addr), .IN_DATA (in_data), .CLR_REQ (clr_req),
`ifdef LATCH_WRITE_SEQ_VERIFY_EN
    .LAT_Q (lat_q), .MISMATCH (d3_mm),
`endif
    .LAT_D (d3_d), .LAT_G (d3_g), .LAT_RSTB (d3_rstb),
    .BUSY (d3_busy), .DONE (d3_done), .ERR (d3_err)
  );

  typedef struct {
    logic       clr;
    logic       valid;
    logic [1:0] addr;
    logic [7:0] data;
    logic       rdy;
    logic [7:0] d;
    logic [3:0] g;
    logic       rstb;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs[NumVec];
  vec_t sb_q[$];

  function automatic vec_t mk(logic clr, logic valid, logic [1:0] addr, logic [7:0] data,
                              logic rdy, logic [7:0] d, logic [3:0] g, logic rstb,
                              logic busy, logic done, logic err);
    vec_t v;
    v.clr = clr; v.valid = valid; v.addr = addr; v.data = data;
    v.rdy = rdy; v.d = d; v.g = g; v.rstb = rstb;
    v.busy = busy; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and sample just after the edge; safety properties checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("def_gate_during_clear", 32'((def_g != 0) && !def_rstb), 0);
    chk("def_gate_onehot", 32'($onehot0(def_g)), 1);
    chk("lng_gate_during_clear", 32'((lng_g != 0) && !lng_rstb), 0);
    chk("lng_gate_onehot", 32'($onehot0(lng_g)), 1);
  endtask

  task automatic drive(input logic clr, input logic valid, input logic [1:0] addr,
                       input logic [7:0] data);
    clr_req  = clr;
    in_valid = valid;
    in_addr  = addr;
    in_data  = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    vec_t e;
    n_pass   = 0;
    n_checks = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 8'h00);
`ifdef LATCH_WRITE_SEQ_VERIFY_EN
    lat_q = 8'h00;
`endif

    // Default config, cycle by cycle after reset release.
    //             clr v  a  data   rdy d      g        rstb busy done err
    vecs[0]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 4'b0000, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2, 8'hA5, 0, 8'hA5, 4'b0000, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 8'h00, 0, 8'hA5, 4'b0100, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 0, 8'hA5, 4'b0000, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 8'h00, 1, 8'hA5, 4'b0000, 1, 0, 1, 0);
    vecs[5]  = mk(0, 1, 0, 8'h3C, 0, 8'h3C, 4'b0000, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 8'h00, 0, 8'h3C, 4'b0001, 1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 8'h00, 0, 8'h3C, 4'b0000, 1, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 8'h00, 1, 8'h3C, 4'b0000, 1, 0, 1, 0);
    vecs[9]  = mk(1, 1, 1, 8'h77, 0, 8'h3C, 4'b0000, 0, 1, 0, 0);
    vecs[10] = mk(0, 1, 1, 8'h77, 1, 8'h3C, 4'b0000, 1, 0, 1, 0);
    vecs[11] = mk(0, 1, 1, 8'h77, 0, 8'h77, 4'b0000, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 8'h00, 0, 8'h77, 4'b0010, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 8'h00, 0, 8'h77, 4'b0000, 1, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 8'h00, 1, 8'h77, 4'b0000, 1, 0, 1, 0);
    vecs[15] = mk(0, 1, 3, 8'hE1, 0, 8'hE1, 4'b0000, 1, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 8'h00, 0, 8'hE1, 4'b1000, 1, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 8'hE1, 4'b0000, 1, 1, 0, 0);
    vecs[18] = mk(0, 0, 0, 8'h00, 1, 8'hE1, 4'b0000, 1, 0, 1, 0);
    vecs[19] = mk(0, 0, 0, 8'h00, 1, 8'hE1, 4'b0000, 1, 0, 0, 0);

    // Reset values.
    tick();
    tick();
    chk("rst_ready", 32'(def_ready), 0);
    chk("rst_d", 32'(def_d), 0);
    chk("rst_g", 32'(def_g), 0);
    chk("rst_rstb", 32'(def_rstb), 1);
    chk("rst_busy", 32'(def_busy), 0);
    chk("rst_done", 32'(def_done), 0);
    chk("rst_err", 32'(def_err), 0);
    chk("rst_lng_ready", 32'(lng_ready), 0);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].clr, vecs[i].valid, vecs[i].addr, vecs[i].data);
      sb_q.push_back(vecs[i]);
      tick();
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_ready", i), 32'(def_ready), 32'(e.rdy));
      chk($sformatf("vec%0d_lat_d", i), 32'(def_d), 32'(e.d));
      chk($sformatf("vec%0d_lat_g", i), 32'(def_g), 32'(e.g));
      chk($sformatf("vec%0d_rstb", i), 32'(def_rstb), 32'(e.rstb));
      chk($sformatf("vec%0d_busy", i), 32'(def_busy), 32'(e.busy));
      chk($sformatf("vec%0d_done", i), 32'(def_done), 32'(e.done));
      chk($sformatf("vec%0d_err", i), 32'(def_err), 32'(e.err));
    end
    drive(0, 0, 0, 8'h00);

    // Long timing: setup 2, pulse 3, hold 2; write to word 0.
    do_reset();
    chk("lng_ready_after_rst", 32'(lng_ready), 1);
    drive(0, 1, 0, 8'hC3);
    tick();
    drive(0, 0, 0, 8'h00);
    for (int c = 0; c <= 8; c++) begin
      chk($sformatf("lng_c%0d_g", c), 32'(lng_g), (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
      chk($sformatf("lng_c%0d_d", c), 32'(lng_d), 32'hC3);
      chk($sformatf("lng_c%0d_done", c), 32'(lng_done), 32'(c == 7));
      chk($sformatf("lng_c%0d_ready", c), 32'(lng_ready), 32'(c >= 7));
      tick();
    end

    // Long timing clear: LAT_RSTB low for 3 cycles, data left alone.
    drive(1, 0, 0, 8'h00);
    tick();
    drive(0, 0, 0, 8'h00);
    for (int c = 0; c <= 4; c++) begin
      chk($sformatf("lclr_c%0d_rstb", c), 32'(lng_rstb), 32'(c >= 3));
      chk($sformatf("lclr_c%0d_done", c), 32'(lng_done), 32'(c == 3));
      chk($sformatf("lclr_c%0d_busy", c), 32'(lng_busy), 32'(c < 3));
      chk($sformatf("lclr_c%0d_d", c), 32'(lng_d), 32'hC3);
      tick();
    end

    // Depth 3: address 3 is dropped with an error pulse.
    do_reset();
    drive(0, 1, 3, 8'h99);
    tick();
    drive(0, 0, 0, 8'h00);
    chk("d3_err_pulse", 32'(d3_err), 1);
    chk("d3_err_ready", 32'(d3_ready), 1);
    chk("d3_err_busy", 32'(d3_busy), 0);
    chk("d3_err_d", 32'(d3_d), 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("d3_c%0d_err", c), 32'(d3_err), 0);
      chk($sformatf("d3_c%0d_done", c), 32'(d3_done), 0);
      chk($sformatf("d3_c%0d_g", c), 32'(d3_g), 0);
      chk($sformatf("d3_c%0d_ready", c), 32'(d3_ready), 1);
    end
    drive(0, 1, 2, 8'h11);
    tick();
    drive(0, 0, 0, 8'h00);
    chk("d3_ok_busy", 32'(d3_busy), 1);
    tick();
    chk("d3_ok_g", 32'(d3_g), 32'b100);

    // Reset while the gate is high aborts without DONE.
    do_reset();
    drive(0, 1, 1, 8'h5E);
    tick();
    drive(0, 0, 0, 8'h00);
    tick();
    chk("abort_pre_g", 32'(def_g), 32'b0010);
    rst = 1'b1;
    tick();
    chk("abort_g", 32'(def_g), 0);
    chk("abort_busy", 32'(def_busy), 0);
    chk("abort_ready", 32'(def_ready), 0);
    chk("abort_rstb", 32'(def_rstb), 1);
    chk("abort_done", 32'(def_done), 0);
    chk("abort_d", 32'(def_d), 0);
    rst = 1'b0;
    tick();
    chk("abort_ready_back", 32'(def_ready), 1);
    chk("abort_no_done", 32'(def_done), 0);
    tick();
    chk("abort_no_done2", 32'(def_done), 0);

`ifdef LATCH_WRITE_SEQ_VERIFY_EN
    // Read-back disagreeing with the written word flags MISMATCH alongside DONE.
    do_reset();
    lat_q = 8'h5A;
    drive(0, 1, 0, 8'hA5);
    tick();
    drive(0, 0, 0, 8'h00);
    tick();
    tick();
    chk("mm_hold_quiet", 32'(def_mm), 0);
    tick();
    chk("mm_bad_done", 32'(def_done), 1);
    chk("mm_bad_flag", 32'(def_mm), 1);
    tick();
    chk("mm_bad_pulse_ends", 32'(def_mm), 0);
    lat_q = 8'hA5;
    drive(0, 1, 0, 8'hA5);
    tick();
    drive(0, 0, 0, 8'h00);
    tick();
    tick();
    tick();
    chk("mm_good_done", 32'(def_done), 1);
    chk("mm_good_flag", 32'(def_mm), 0);
    lat_q = 8'h01;
    drive(1, 0, 0, 8'h00);
    tick();
    drive(0, 0, 0, 8'h00);
    tick();
    chk("mm_clr_done", 32'(def_done), 1);
    chk("mm_clr_flag", 32'(def_mm), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
